// File: rtl/sprite_pixel_writer.sv
// Walks one sprite bitmap from the sprite ROM in raster order and hands each
// visible, non-transparent pixel to the LT24 driver over a write/ready handshake.
module sprite_pixel_writer #(
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 32,
  parameter int unsigned SCREEN_W    = 240,
  parameter int unsigned SCREEN_H    = 320,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int unsigned ROM_AW      = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_start,
  input  logic [7:0]        x_sprite,
  input  logic [8:0]        y_sprite,
  input  logic [3:0]        sprite_id,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        lcd_x,
  output logic [8:0]        lcd_y,
  output logic [15:0]       lcd_colour,
  output logic              lcd_write,
  input  logic              lcd_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
  localparam logic [9:0]    X_LIM    = 10'(SCREEN_W);
  localparam logic [9:0]    Y_LIM    = 10'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CHECK,
    S_EMIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [7:0]        x_lat_q, x_lat_d;
  logic [8:0]        y_lat_q, y_lat_d;
  logic [3:0]        id_lat_q, id_lat_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        lcd_x_q, lcd_x_d;
  logic [8:0]        lcd_y_q, lcd_y_d;
  logic [15:0]       lcd_colour_q, lcd_colour_d;
  logic              lcd_write_q, lcd_write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [9:0]        px, py;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_lat_d      = x_lat_q;
    y_lat_d      = y_lat_q;
    id_lat_d     = id_lat_q;
    rom_addr_d   = rom_addr_q;
    lcd_x_d      = lcd_x_q;
    lcd_y_d      = lcd_y_q;
    lcd_colour_d = lcd_colour_q;
    lcd_write_d  = lcd_write_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    // Screen coordinates widened to 10 bits so sprites hanging off the edge never wrap.
    px = 10'(x_lat_q) + 10'(col_q);
    py = 10'(y_lat_q) + 10'(row_q);

    case (state_q)
      S_IDLE: begin
        if (draw_start) begin
          x_lat_d  = x_sprite;
          y_lat_d  = y_sprite;
          id_lat_d = sprite_id;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_addr_d = ROM_AW'(id_lat_q) * ROM_AW'(SPRITE_W * SPRITE_H)
                   + ROM_AW'(row_q) * ROM_AW'(SPRITE_W)
                   + ROM_AW'(col_q);
        state_d    = S_WAIT;
      end
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        if (rom_data == TRANSPARENT || px >= X_LIM || py >= Y_LIM) begin
          state_d = S_ADVANCE;
        end else begin
          lcd_x_d      = px[7:0];
          lcd_y_d      = py[8:0];
          lcd_colour_d = rom_data;
          lcd_write_d  = 1'b1;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (lcd_ready) begin
          lcd_write_d = 1'b0;
          state_d     = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (col_q != COL_LAST) begin
          col_d   = col_q + CW'(1);
          state_d = S_FETCH;
        end else if (row_q != ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      id_lat_q     <= '0;
      rom_addr_q   <= '0;
      lcd_x_q      <= '0;
      lcd_y_q      <= '0;
      lcd_colour_q <= '0;
      lcd_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      id_lat_q     <= id_lat_d;
      rom_addr_q   <= rom_addr_d;
      lcd_x_q      <= lcd_x_d;
      lcd_y_q      <= lcd_y_d;
      lcd_colour_q <= lcd_colour_d;
      lcd_write_q  <= lcd_write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign lcd_x      = lcd_x_q;
  assign lcd_y      = lcd_y_q;
  assign lcd_colour = lcd_colour_q;
  assign lcd_write  = lcd_write_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/sprite_pixel_writer.md
Name: sprite_pixel_writer

Overview:
- Downstream stage of the player sprite updater. Consumes the per-tick sprite position (xSprite, ySprite) and animation frame (spriteId).
- Each tick it walks the selected sprite bitmap in a sprite ROM and issues pixel writes to the LT24 LCD driver using a write/ready handshake.
- Pixels that are transparent or fall off-screen are skipped. Raises done after the last pixel.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- SCREEN_W, 240, LCD width; x >= SCREEN_W is off-screen
- SCREEN_H, 320, LCD height; y >= SCREEN_H is off-screen
- TRANSPARENT, 16'hF81F, RGB565 key colour that is never written
- ROM_AW, 14, ROM address width; must be >= log2(16*SPRITE_W*SPRITE_H)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- draw_start  in  1  one-cycle pulse; begin drawing the sprite
- x_sprite  in  8  top-left x; sampled on accepted draw_start
- y_sprite  in  9  top-left y; sampled on accepted draw_start
- sprite_id  in  4  frame index; sampled on accepted draw_start
- rom_addr  out  ROM_AW  sprite ROM address
- rom_data  in  16  RGB565 pixel; valid exactly 1 cycle after rom_addr
- lcd_x  out  8  pixel x
- lcd_y  out  9  pixel y
- lcd_colour  out  16  pixel colour
- lcd_write  out  1  pixel-write request
- lcd_ready  in  1  LCD driver accepts the pixel when high with lcd_write high
- busy  out  1  high from acceptance of draw_start until done
- done  out  1  one-cycle pulse after the final pixel is handled

Behaviour:
- Reset (async):
  - state=IDLE; col=row=0.
  - rom_addr=0, lcd_x=0, lcd_y=0, lcd_colour=0.
  - lcd_write=0, busy=0, done=0.
- States:
  - IDLE: on draw_start, latch x_sprite/y_sprite/sprite_id, clear col/row, set busy, go to FETCH. Otherwise stay.
  - FETCH: drive rom_addr = sprite_id*SPRITE_W*SPRITE_H + row*SPRITE_W + col (zero-extended, truncated to ROM_AW). Go to WAIT.
  - WAIT: rom_data becomes valid. Go to CHECK.
  - CHECK: compute px = x_lat+col and py = y_lat+row, at 10-bit width (no wrap).
    - If rom_data == TRANSPARENT, or px >= SCREEN_W, or py >= SCREEN_H: skip; go to ADVANCE.
    - Otherwise register lcd_x=px[7:0], lcd_y=py[8:0], lcd_colour=rom_data, assert lcd_write, go to EMIT.
  - EMIT: hold lcd_write, lcd_x, lcd_y and lcd_colour stable until a rising edge where lcd_ready=1. On that edge deassert lcd_write and go to ADVANCE.
  - ADVANCE:
    - If col < SPRITE_W-1: col++, go to FETCH.
    - Else if row < SPRITE_H-1: col=0, row++, go to FETCH.
    - Else: go to DONE.
  - DONE: pulse done for one cycle, clear busy, return to IDLE.
- Timing:
  - Minimum 4 cycles per skipped pixel (FETCH, WAIT, CHECK, ADVANCE).
  - Minimum 5 cycles per written pixel, when lcd_ready is already high in EMIT.
  - busy rises the cycle after draw_start.
- Boundary conditions:
  - draw_start while busy: ignored. Latched coordinates and id are unchanged.
  - lcd_ready high outside EMIT: ignored.
  - lcd_ready held low: wait indefinitely in EMIT with outputs stable. There is no timeout.
  - Raster order is row-major, col fastest; writes never go out of this order.
  - Input changes after draw_start do not affect the frame in progress.
  - Reset mid-frame: abort immediately. lcd_write drops, no done pulse, back to IDLE.

Test Plan:
- Reset mid-EMIT with lcd_ready=0 -> lcd_write, busy and done all 0 asynchronously; next draw_start restarts at row 0, col 0.
- ROM all opaque 16'h07E0, x=10, y=20, id=0, lcd_ready tied 1 -> 1024 writes:
  - first (10,20), last (41,51), all colour 16'h07E0;
  - done exactly once; total frame 5*1024+2 cycles from draw_start.
- id=3, ROM region 3072..4095 all TRANSPARENT -> zero lcd_write pulses, rom_addr spans 3072..4095, done asserted.
- x=230, y=310, opaque ROM -> only px 230..239 and py 310..319 are written (100 writes); no lcd_x >= 240 or lcd_y >= 320.
- lcd_ready low for 7 cycles on the 3rd pixel -> lcd_write, lcd_x, lcd_y and lcd_colour stay constant for those cycles; the pixel is written once with no duplicate.
- Second draw_start pulsed while busy with different x/y/id -> frame completes with the original values; exactly 1 done pulse.
